// File: rtl/pc_redirect_unit.sv
// Program counter owner: accepts redirect targets, flushes fetch for a fixed
// window after a redirect, and traps (sticky until reset) on misaligned targets.
module pc_redirect_unit #(
    parameter int                   WORD_SIZE    = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC     = '0,
    parameter int                   FLUSH_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 stall_i,
    input  logic                 redir_valid_i,
    input  logic [1:0]           redir_kind_i,
    input  logic [WORD_SIZE-1:0] redir_target_i,
    output logic                 redir_ready_o,
    output logic [WORD_SIZE-1:0] pc_o,
    output logic [WORD_SIZE-1:0] pc_plus4_o,
    output logic                 fetch_valid_o,
    output logic                 flush_o,
    output logic                 misalign_trap_o,
    output logic [WORD_SIZE-1:0] trap_pc_o
);

    localparam logic [3:0] FLUSH_CNT = 4'(FLUSH_CYCLES);
    localparam logic [1:0] KIND_JALR = 2'b10;
    localparam logic [1:0] KIND_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] trap_pc_q;

    logic [WORD_SIZE-1:0] eff_target;
    logic                 misaligned;
    logic                 accept;

    always_comb begin
        eff_target = redir_target_i;
        if (redir_kind_i == KIND_JALR) eff_target[0] = 1'b0;
    end

    assign misaligned = (eff_target[1:0] != 2'b00);
    assign accept     = redir_valid_i && redir_ready_o && (redir_kind_i != KIND_RSVD);

    // Redirect beats stall; a misaligned redirect leaves the PC where it is.
    always_comb begin
        pc_d = pc_q;
        if (state_q == ST_RUN) begin
            if (accept) begin
                if (!misaligned) pc_d = eff_target;
            end else if (!stall_i) begin
                pc_d = pc_q + WORD_SIZE'(4);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_RUN;
            cnt_q     <= 4'd0;
            pc_q      <= RESET_PC;
            trap_pc_q <= '0;
        end else begin
            pc_q <= pc_d;
            unique case (state_q)
                ST_RUN: begin
                    if (accept && misaligned) begin
                        state_q   <= ST_TRAP;
                        trap_pc_q <= eff_target;
                    end else if (accept) begin
                        state_q <= ST_FLUSH;
                        cnt_q   <= FLUSH_CNT;
                    end
                end
                ST_FLUSH: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_q <= ST_RUN;
                end
                ST_TRAP: ;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    // Status outputs are forced quiet while reset is held.
    assign redir_ready_o   = (state_q == ST_RUN) && !reset_i;
    assign fetch_valid_o   = (state_q == ST_RUN) && !reset_i;
    assign flush_o         = (state_q != ST_RUN) && !reset_i;
    assign misalign_trap_o = (state_q == ST_TRAP) && !reset_i;
    assign pc_o            = pc_q;
    assign pc_plus4_o      = pc_q + WORD_SIZE'(4);
    assign trap_pc_o       = trap_pc_q;

endmodule
